// File: rtl/sub_reservation_station.sv
// sub_reservation_station
// Holds decoded subtract operations until both source operands are valid,
// snooping the CDB for missing operands, and dispatches the oldest ready
// entry (one per cycle) as a registered ReservationStation record.
//
// Ports:
//   clk, RSTN_N           clock, async active-low reset
//   issue_valid/ready     issue handshake; ready = a free entry exists
//   issue_alu1/2          source tags (0 = value already valid)
//   issue_value1/2        operand values
//   issue_dest            destination tag of the operation
//   cdb_valid/tag/value   common data bus broadcast
//   exec_ready            Sub unit can take a dispatch this cycle
//   rstation              registered dispatched record (busy=0 when idle)
//   dispatch_dest         destination tag of the record on rstation
//   occupancy             number of busy entries

package sub_rs_pkg;
    typedef struct packed {
        logic        busy;
        logic [7:0]  alu1;
        logic [7:0]  alu2;
        logic [31:0] value1;
        logic [31:0] value2;
    } ReservationStation;
endpackage

module sub_reservation_station
    import sub_rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AGE_W = 4
) (
    input  logic                         clk,
    input  logic                         RSTN_N,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [7:0]                   issue_alu1,
    input  logic [7:0]                   issue_alu2,
    input  logic [31:0]                  issue_value1,
    input  logic [31:0]                  issue_value2,
    input  logic [7:0]                   issue_dest,
    input  logic                         cdb_valid,
    input  logic [7:0]                   cdb_tag,
    input  logic [31:0]                  cdb_value,
    input  logic                         exec_ready,
    output ReservationStation            rstation,
    output logic [7:0]                   dispatch_dest,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    logic [DEPTH-1:0] busy_q;
    logic [7:0]       alu1_q   [DEPTH];
    logic [7:0]       alu2_q   [DEPTH];
    logic [31:0]      value1_q [DEPTH];
    logic [31:0]      value2_q [DEPTH];
    logic [7:0]       dest_q   [DEPTH];
    logic [AGE_W-1:0] age_q    [DEPTH];

    logic [OCC_W-1:0] occ_c;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [AGE_W-1:0] sel_age;
    logic             do_issue;
    logic             do_disp;
    logic             byp1;
    logic             byp2;

    always_comb begin
        occ_c      = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_c = occ_c + OCC_W'(busy_q[i]);
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Strict '>' keeps the lowest index on equal (e.g. saturated) ages.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && alu1_q[i] == 8'd0 && alu2_q[i] == 8'd0 &&
                (!sel_found || age_q[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
        end
    end

    assign occupancy   = occ_c;
    assign issue_ready = RSTN_N && (occ_c < DEPTH_C);
    assign do_issue    = issue_valid && issue_ready;
    assign do_disp     = exec_ready && sel_found;
    assign byp1        = cdb_valid && issue_alu1 != 8'd0 && issue_alu1 == cdb_tag;
    assign byp2        = cdb_valid && issue_alu2 != 8'd0 && issue_alu2 == cdb_tag;

    always_ff @(posedge clk or negedge RSTN_N) begin
        if (!RSTN_N) begin
            busy_q        <= '0;
            rstation      <= '0;
            dispatch_dest <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                alu1_q[i]   <= '0;
                alu2_q[i]   <= '0;
                value1_q[i] <= '0;
                value2_q[i] <= '0;
                dest_q[i]   <= '0;
                age_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i]) begin
                    if (do_disp && sel_idx == IDX_W'(i)) begin
                        busy_q[i] <= 1'b0;
                    end else if (age_q[i] != '1) begin
                        age_q[i] <= age_q[i] + 1'b1;
                    end
                    if (cdb_valid && alu1_q[i] != 8'd0 && alu1_q[i] == cdb_tag) begin
                        alu1_q[i]   <= 8'd0;
                        value1_q[i] <= cdb_value;
                    end
                    if (cdb_valid && alu2_q[i] != 8'd0 && alu2_q[i] == cdb_tag) begin
                        alu2_q[i]   <= 8'd0;
                        value2_q[i] <= cdb_value;
                    end
                end else if (do_issue && free_idx == IDX_W'(i)) begin
                    busy_q[i]   <= 1'b1;
                    age_q[i]    <= '0;
                    dest_q[i]   <= issue_dest;
                    alu1_q[i]   <= byp1 ? 8'd0 : issue_alu1;
                    alu2_q[i]   <= byp2 ? 8'd0 : issue_alu2;
                    value1_q[i] <= byp1 ? cdb_value : issue_value1;
                    value2_q[i] <= byp2 ? cdb_value : issue_value2;
                end
            end

            if (do_disp) begin
                rstation.busy   <= 1'b1;
                rstation.alu1   <= 8'd0;
                rstation.alu2   <= 8'd0;
                rstation.value1 <= value1_q[sel_idx];
                rstation.value2 <= value2_q[sel_idx];
                dispatch_dest   <= dest_q[sel_idx];
            end else begin
                rstation      <= '0;
                dispatch_dest <= 8'd0;
            end
        end
    end
endmodule

// File: doc/sub_reservation_station.md
# sub_reservation_station

Reservation station that feeds the Sub execution unit. It accepts decoded subtract operations from the issue stage and holds them until both source operands are valid. It captures missing operands by snooping the common data bus (CDB), then dispatches the oldest ready entry, one per cycle, as a registered `ReservationStation` record that the Sub unit consumes on the following edge.

## Interface
Parameters:
- DEPTH, 4 — number of entries, 2..8
- AGE_W, 4 — width of the per-entry saturating age counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- RSTN_N  in  1  reset, asynchronous, active-low
- issue_valid  in  1  issue stage presents an operation
- issue_ready  out  1  at least one free entry; forced 0 while RSTN_N low
- issue_alu1, issue_alu2  in  8 each  source tags; 8'd0 means the value is already valid
- issue_value1, issue_value2  in  32 each  operand values; meaningful only where the tag is 0
- issue_dest  in  8  destination tag of the operation; nonzero
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  8  tag being broadcast; nonzero when cdb_valid
- cdb_value  in  32  broadcast value
- exec_ready  in  1  Sub unit can accept a dispatch this cycle
- rstation  out  ReservationStation  dispatched record: busy, alu1, alu2, value1, value2
- dispatch_dest  out  8  destination tag of the record on rstation
- occupancy  out  $clog2(DEPTH+1)  number of busy entries

## Operation
Each entry holds busy, alu1, alu2, value1, value2, dest and age.

**Issue**
- An operation is accepted on an edge where issue_valid && issue_ready.
- It is written to the lowest-index free entry with busy=1 and age=0.

**Issue bypass**
- If cdb_valid and cdb_tag equals a nonzero issue_aluK on the same edge, the entry stores valueK=cdb_value and aluK=0.
- The entry is therefore born ready.

**Snoop**
- Every edge, for every busy entry and each K in {1,2}: if cdb_valid && aluK!=0 && aluK==cdb_tag, then valueK<=cdb_value and aluK<=0.
- Both operands may match the same broadcast.

**Ready**
- An entry is ready when busy && alu1==0 && alu2==0, evaluated on registered state.
- A snoop capture makes the entry ready only from the next cycle.

**Select**
- Among ready entries, pick the maximum age; ties go to the lowest index.

**Dispatch** (edge where exec_ready=1 and a ready entry exists)
- rstation gets {busy=1, alu1=0, alu2=0, value1, value2} of the selected entry.
- dispatch_dest gets its dest.
- The entry's busy is cleared on the same edge.

**No dispatch** (otherwise)
- rstation<=all zero, so busy=0.
- dispatch_dest<=0.

**Age**
- Every edge, each busy entry that is not dispatched increments age, saturating at 2^AGE_W-1.

**issue_ready / occupancy**
- Both are combinational from the registered busy bits: issue_ready = (occupancy < DEPTH).
- A slot freed by dispatch becomes visible to issue in the cycle after the dispatch edge.
- There is no same-edge reuse.

**Arithmetic**
- None in this block; values pass through unchanged, 32 bits.

## Timing
- Reset (async assert): all entries busy=0; rstation all zero; dispatch_dest=0; occupancy=0; issue_ready=0 until RSTN_N deasserts.
- Reset mid-operation: all pending entries and any record on rstation are discarded immediately, with no dispatch.
- Issue-to-dispatch latency with both operands valid at issue:
  - accepted at edge N;
  - rstation.busy=1 during the cycle after edge N+1;
  - Sub result at edge N+2.
- Operand arriving on the CDB at edge M: earliest dispatch at edge M+1.
- rstation.busy is high for exactly one cycle per dispatched entry; back-to-back dispatches give consecutive busy cycles.
- Full: with occupancy==DEPTH, issue_ready=0 and issue_valid is ignored.
- Simultaneous issue and dispatch when full: the dispatch proceeds, the issue is not accepted, and issue_ready rises the next cycle.
- Simultaneous issue, snoop and dispatch on one edge are all permitted and independent.
- exec_ready=0: entries are held, ages continue to increment, and rstation.busy=0.

## Test plan
- Ready issue: issue tags 0/0, values 32'd10/32'd3, dest 8'h05 -> one-cycle rstation {busy=1, value1=10, value2=3}, dispatch_dest=05, at the second cycle after acceptance.
- Snoop wake-up: issue alu1=8'h07, value2=5, then cdb {07, 32'd20} three cycles later -> no dispatch before the broadcast; dispatch with value1=20, value2=5 one edge after the broadcast.
- Bypass: issue alu2=8'h09 on the same edge as cdb {09, 32'hFFFF_FFFF} -> dispatched next edge with value2=FFFF_FFFF.
- Full/oldest: fill 4 entries waiting on tag 8'h0A, then hold issue_valid=1 -> issue_ready=0 and occupancy=4; after broadcast of 0A, 4 consecutive dispatches in issue order; issue_ready=1 one cycle after the first dispatch.
- Backpressure: exec_ready=0 with 2 ready entries for 5 cycles -> rstation.busy stays 0; on exec_ready=1, the older entry dispatches first.
- Async reset with 3 busy entries and rstation.busy=1 -> all outputs zero immediately; after release, occupancy=0 and issue_ready=1.
